cp0_exception_ctrl: RTL and testbench
=====================================

// Module: cp0_exception_ctrl
// PURPOSE
//  Coprocessor-0 exception/interrupt controller for the pipelined MIPS32 core. It is the producer side of the
//  next-PC redirect interface: it drives the exception, eret and EPC-return signals that next-PC selection consumes.
//  Holds Status/Cause/EPC/Count/Compare, serves mfc0/mtc0, and takes interrupts and decode-stage exceptions.
//  The handler vector (32'd12) is fixed in next-PC selection; this block only asserts the request.
// PARAMETERS
//  N_HWIRQ   5   external interrupt lines (Cause.IP[6:2]; IP[7] is the timer)
//  SYNC_DEPTH 2  flops in the external-IRQ synchronizer
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_rst          in   1   asynchronous reset, active-high
//  i_irq          in   5   external interrupt requests, asynchronous, level
//  i_pc_dec       in   32  PC of the instruction in decode
//  i_syscall_dec  in   1   decode: syscall
//  i_ri_dec       in   1   decode: reserved/illegal instruction
//  i_eret_dec     in   1   decode: eret
//  i_mtc0_dec     in   1   decode: mtc0 (write o_rdata-addressed reg)
//  i_cp0_addr     in   5   CP0 register number (rd field)
//  i_cp0_wdata    in   32  mtc0 write data (rt value)
//  i_s_rst_dec    in   1   decode stall; while high, nothing in decode is accepted
//  o_exeption     out  1   take exception this cycle (redirect to vector)
//  o_eret         out  1   eret accepted this cycle (redirect to o_epc_to_pc)
//  o_epc_to_pc    out  32  current EPC
//  o_cp0_rdata    out  32  mfc0 read data, combinational on i_cp0_addr
//  o_flush        out  1   squash the instruction in fetch (one cycle after redirect)
// BEHAVIOUR
//  Reset: Status=0 (IE=0, EXL=0, IM=0), Cause=0, EPC=0, Count=0, Compare=32'hFFFF_FFFF, sync flops=0, FSM=RUN;
//   all outputs 0 except o_epc_to_pc=0, o_cp0_rdata=reg at addr. Reset mid-handler simply returns to this state.
//  Registers: 9 Count, 11 Compare, 12 Status {IM[15:8], EXL[1], IE[0]}, 13 Cause {IP[15:10] RO, ExcCode[6:2] RO},
//   14 EPC. Other addresses read 0; unimplemented bits read 0; writes to them are ignored.
//  Count increments every cycle, wraps 32'hFFFF_FFFF->0. Count==Compare sets timer-pending (IP[7]) next edge;
//   mtc0 to Compare clears it. mtc0 to Count loads value (no increment that cycle).
//  i_irq synchronized through SYNC_DEPTH flops -> IP[6:2] (level, not latched).
//  int_req = IE & ~EXL & |(IP & IM). accept = ~i_s_rst_dec & state==RUN.
//  Priority within an accepted cycle: RI (ExcCode 10) > syscall (8) > interrupt (0) > eret > mtc0.
//  Exception taken (accept & (ri|syscall|int_req)): o_exeption=1 combinationally; at edge EPC<=i_pc_dec,
//   ExcCode<=code, EXL<=1, FSM->FLUSH; a simultaneous mtc0 is suppressed (instruction is squashed).
//  eret (accept & i_eret_dec & EXL): o_eret=1 same cycle, EXL<=0 at edge, FSM->FLUSH. eret with EXL=0 is a NOP.
//  FLUSH: o_flush=1 for exactly one cycle, no events accepted, then RUN. Latency request->redirect = 0 cycles.
//  Interrupt pending during eret: masked by EXL that cycle; taken no earlier than the RUN cycle after FLUSH.
//  While i_s_rst_dec=1: no redirect, no mtc0, Count/IP still update, requests held by decode, not lost.
//  mfc0 read of a reg written by mtc0 in the same cycle returns the old value.
// STRUCTURE
//  Shared pkg (cp0_defs): CP0 register numbers, Status/Cause bit positions, ExcCode constants, FSM encoding.
//  One sub-module: cp0_irq_sync (parameterized N_HWIRQ x SYNC_DEPTH synchronizer). FSM + regs in this module.
// TESTING
//  Reset: drive i_rst mid-FLUSH -> all regs reset values, o_flush=0, Compare reads 32'hFFFF_FFFF.
//  mtc0 Status=32'h0000_0401, i_irq[0]=1 -> o_exeption=1 exactly 2 cycles later, EPC=i_pc_dec, ExcCode=0, EXL=1.
//  syscall at PC 32'h40 with RI same cycle -> ExcCode=10, EPC=32'h40; next cycle o_flush=1, o_exeption=0.
//  eret with EXL=1 -> o_eret=1, o_epc_to_pc=EPC, EXL=0; eret with EXL=0 -> o_eret=0, no state change.
//  Compare=5, Count=0, IM7=1, IE=1 -> timer exception when IP[7] set; mtc0 Compare clears IP[7].
//  Stall: syscall held with i_s_rst_dec=1 for 3 cycles -> no o_exeption; taken on first unstalled cycle.

Source files
------------

// File: rtl/cp0_exception_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes,
// controller FSM encoding and register packing helpers.
package cp0_exception_ctrl_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam int ST_IE_BIT  = 0;
    localparam int ST_EXL_BIT = 1;
    localparam int ST_IM_LO   = 8;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } cp0_state_e;

    function automatic logic [31:0] pack_status(input logic [7:0] im,
                                                input logic       exl,
                                                input logic       ie);
        return {16'd0, im, 6'd0, exl, ie};
    endfunction

    // Cause layout: IP in bits [15:8], ExcCode in bits [6:2], all other bits zero.
    function automatic logic [31:0] pack_cause(input logic [7:0] ip,
                                               input logic [4:0] exc_code);
        return {16'd0, ip, 1'b0, exc_code, 2'd0};
    endfunction

endpackage

// File: rtl/cp0_exception_ctrl_irq_sync.sv
// Multi-flop synchronizer bringing the asynchronous external interrupt
// levels into the core clock domain.
module cp0_exception_ctrl_irq_sync #(
    parameter int N_HWIRQ    = 5,
    parameter int SYNC_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_HWIRQ-1:0] irq_async,
    output logic [N_HWIRQ-1:0] irq_sync
);

    logic [N_HWIRQ-1:0] stage_r [SYNC_DEPTH];

    // Shift the sampled interrupt levels through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                stage_r[i] <= {N_HWIRQ{1'b0}};
            end
        end else begin
            stage_r[0] <= irq_async;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign irq_sync = stage_r[SYNC_DEPTH-1];

endmodule

// File: rtl/cp0_exception_ctrl.sv
// Coprocessor-0 exception/interrupt controller: Status/Cause/EPC/Count/Compare,
// mfc0/mtc0 access, and the exception/eret redirect requests to next-PC select.
module cp0_exception_ctrl
    import cp0_exception_ctrl_pkg::*;
#(
    parameter int N_HWIRQ    = 5,
    parameter int SYNC_DEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_HWIRQ-1:0] i_irq,
    input  logic [31:0]        i_pc_dec,
    input  logic               i_syscall_dec,
    input  logic               i_ri_dec,
    input  logic               i_eret_dec,
    input  logic               i_mtc0_dec,
    input  logic [4:0]         i_cp0_addr,
    input  logic [31:0]        i_cp0_wdata,
    input  logic               i_s_rst_dec,
    output logic               o_exeption,
    output logic               o_eret,
    output logic [31:0]        o_epc_to_pc,
    output logic [31:0]        o_cp0_rdata,
    output logic               o_flush
);

    cp0_state_e state_r;
    cp0_state_e state_nxt_s;

    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic [31:0] epc_r;
    logic [7:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic [4:0]  exc_code_r;
    logic        timer_pend_r;

    logic [N_HWIRQ-1:0] irq_sync_s;
    logic [4:0]         hw_ip_s;
    logic [7:0]         ip_s;
    logic               accept_s;
    logic               int_req_s;
    logic               exc_take_s;
    logic               eret_take_s;
    logic               mtc0_take_s;
    logic [4:0]         exc_code_s;
    logic               wr_count_s;
    logic               wr_compare_s;
    logic               wr_status_s;
    logic               wr_epc_s;

    cp0_exception_ctrl_irq_sync #(
        .N_HWIRQ    (N_HWIRQ),
        .SYNC_DEPTH (SYNC_DEPTH)
    ) u_irq_sync (
        .clk       (i_clk),
        .rst       (i_rst),
        .irq_async (i_irq),
        .irq_sync  (irq_sync_s)
    );

    assign hw_ip_s = 5'(irq_sync_s);
    assign ip_s    = {timer_pend_r, hw_ip_s, 2'b00};

    // Decode acceptance, event priority and the mtc0 write strobes.
    always_comb begin
        accept_s    = ~i_s_rst_dec & (state_r == ST_RUN);
        int_req_s   = ie_r & ~exl_r & (|(ip_s & im_r));
        exc_take_s  = accept_s & (i_ri_dec | i_syscall_dec | int_req_s);
        eret_take_s = accept_s & ~exc_take_s & i_eret_dec & exl_r;
        // A squashed instruction (exception) or a redirecting eret never writes CP0.
        mtc0_take_s = accept_s & ~exc_take_s & ~eret_take_s & i_mtc0_dec;
        if (i_ri_dec) begin
            exc_code_s = EXC_RI;
        end else if (i_syscall_dec) begin
            exc_code_s = EXC_SYS;
        end else begin
            exc_code_s = EXC_INT;
        end
        wr_count_s   = mtc0_take_s & (i_cp0_addr == CP0_COUNT);
        wr_compare_s = mtc0_take_s & (i_cp0_addr == CP0_COMPARE);
        wr_status_s  = mtc0_take_s & (i_cp0_addr == CP0_STATUS);
        wr_epc_s     = mtc0_take_s & (i_cp0_addr == CP0_EPC);
    end

    // FSM next state: any redirect is followed by exactly one flush cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (exc_take_s | eret_take_s) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: state_nxt_s = ST_RUN;
            default:  state_nxt_s = ST_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Free-running Count, Compare and the timer-pending flag (IP7).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_r      <= 32'd0;
            compare_r    <= 32'hFFFF_FFFF;
            timer_pend_r <= 1'b0;
        end else begin
            if (wr_count_s) begin
                count_r <= i_cp0_wdata;
            end else begin
                count_r <= count_r + 32'd1;
            end
            if (wr_compare_s) begin
                compare_r    <= i_cp0_wdata;
                timer_pend_r <= 1'b0;
            end else if (count_r == compare_r) begin
                timer_pend_r <= 1'b1;
            end
        end
    end

    // Status, Cause.ExcCode and EPC updates from exceptions, eret and mtc0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            im_r       <= 8'd0;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            exc_code_r <= 5'd0;
            epc_r      <= 32'd0;
        end else begin
            if (exc_take_s) begin
                exl_r      <= 1'b1;
                exc_code_r <= exc_code_s;
                epc_r      <= i_pc_dec;
            end else if (eret_take_s) begin
                exl_r <= 1'b0;
            end else begin
                if (wr_status_s) begin
                    im_r  <= i_cp0_wdata[ST_IM_LO +: 8];
                    exl_r <= i_cp0_wdata[ST_EXL_BIT];
                    ie_r  <= i_cp0_wdata[ST_IE_BIT];
                end
                if (wr_epc_s) begin
                    epc_r <= i_cp0_wdata;
                end
            end
        end
    end

    // mfc0 read mux; always shows the pre-write register contents.
    always_comb begin
        o_cp0_rdata = 32'd0;
        case (i_cp0_addr)
            CP0_COUNT:   o_cp0_rdata = count_r;
            CP0_COMPARE: o_cp0_rdata = compare_r;
            CP0_STATUS:  o_cp0_rdata = pack_status(im_r, exl_r, ie_r);
            CP0_CAUSE:   o_cp0_rdata = pack_cause(ip_s, exc_code_r);
            CP0_EPC:     o_cp0_rdata = epc_r;
            default:     o_cp0_rdata = 32'd0;
        endcase
    end

    assign o_exeption  = exc_take_s;
    assign o_eret      = eret_take_s;
    assign o_epc_to_pc = epc_r;
    assign o_flush     = (state_r == ST_FLUSH);

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Directed self-checking bench for cp0_exception_ctrl: reset, interrupt,
// exception priority, eret, timer, decode stall and reset during flush.
module tb_cp0_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  irq;
    logic [31:0] pc_dec;
    logic        syscall_dec;
    logic        ri_dec;
    logic        eret_dec;
    logic        mtc0_dec;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        s_rst_dec;
    logic        exeption;
    logic        eret;
    logic [31:0] epc_to_pc;
    logic [31:0] cp0_rdata;
    logic        flush;

    int nvec = 0;
    int nerr = 0;

    always #10 clk = ~clk;

    cp0_exception_ctrl #(
        .N_HWIRQ    (5),
        .SYNC_DEPTH (2)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_irq         (irq),
        .i_pc_dec      (pc_dec),
        .i_syscall_dec (syscall_dec),
        .i_ri_dec      (ri_dec),
        .i_eret_dec    (eret_dec),
        .i_mtc0_dec    (mtc0_dec),
        .i_cp0_addr    (cp0_addr),
        .i_cp0_wdata   (cp0_wdata),
        .i_s_rst_dec   (s_rst_dec),
        .o_exeption    (exeption),
        .o_eret        (eret),
        .o_epc_to_pc   (epc_to_pc),
        .o_cp0_rdata   (cp0_rdata),
        .o_flush       (flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a);
        cp0_addr = a;
        #1;
    endtask

    task automatic idle();
        syscall_dec = 1'b0;
        ri_dec      = 1'b0;
        eret_dec    = 1'b0;
        mtc0_dec    = 1'b0;
        s_rst_dec   = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        irq       = 5'd0;
        pc_dec    = 32'd0;
        cp0_addr  = 5'd0;
        cp0_wdata = 32'd0;
        idle();
        tick();
        tick();
        chk("rst_exc",   32'(exeption), 32'd0);
        chk("rst_eret",  32'(eret), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_epc",   epc_to_pc, 32'd0);
        rd(5'd11); chk("rst_compare", cp0_rdata, 32'hFFFF_FFFF);
        rd(5'd12); chk("rst_status",  cp0_rdata, 32'd0);
        rd(5'd13); chk("rst_cause",   cp0_rdata, 32'd0);
        rst = 1'b0;

        // Enable IP2 + IE while raising irq[0]; the write is not visible to mfc0 yet
        tick();
        mtc0_dec = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
        irq = 5'b00001; pc_dec = 32'h100;
        #1;
        chk("mfc0_old_status", cp0_rdata, 32'd0);
        chk("irq_cyc0", 32'(exeption), 32'd0);
        tick();
        mtc0_dec = 1'b0;
        #1;
        chk("status_written", cp0_rdata, 32'h0000_0401);
        chk("irq_cyc1", 32'(exeption), 32'd0);
        tick();
        pc_dec = 32'h104;
        #1;
        chk("irq_cyc2", 32'(exeption), 32'd1);
        tick();
        irq = 5'd0;
        #1;
        chk("irq_flush", 32'(flush), 32'd1);
        chk("irq_flush_noexc", 32'(exeption), 32'd0);
        chk("irq_epc_out", epc_to_pc, 32'h104);
        rd(5'd13); chk("irq_cause", cp0_rdata, 32'h0000_0400);
        rd(5'd12); chk("irq_status_exl", cp0_rdata, 32'h0000_0403);

        // Back in RUN with EXL=1: pending IP2 masked; eret accepted
        tick();
        chk("exl_mask_flush", 32'(flush), 32'd0);
        chk("exl_mask_exc", 32'(exeption), 32'd0);
        eret_dec = 1'b1;
        #1;
        chk("eret_take", 32'(eret), 32'd1);
        chk("eret_epc", epc_to_pc, 32'h104);
        tick();
        chk("eret_flush", 32'(flush), 32'd1);
        chk("eret_in_flush", 32'(eret), 32'd0);
        eret_dec = 1'b0;
        rd(5'd12); chk("eret_status", cp0_rdata, 32'h0000_0401);
        tick();
        eret_dec = 1'b1;
        #1;
        chk("eret_exl0", 32'(eret), 32'd0);
        chk("eret_exl0_exc", 32'(exeption), 32'd0);
        rd(5'd5); chk("unimpl_reg", cp0_rdata, 32'd0);
        tick();
        eret_dec = 1'b0;
        #1;
        chk("eret_exl0_noflush", 32'(flush), 32'd0);
        rd(5'd12); chk("eret_exl0_status", cp0_rdata, 32'h0000_0401);

        // syscall + RI + mtc0 EPC together: RI wins, mtc0 squashed
        syscall_dec = 1'b1; ri_dec = 1'b1; pc_dec = 32'h40;
        mtc0_dec = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD;
        #1;
        chk("ri_sys_exc", 32'(exeption), 32'd1);
        tick();
        idle();
        #1;
        chk("ri_flush", 32'(flush), 32'd1);
        chk("ri_flush_noexc", 32'(exeption), 32'd0);
        rd(5'd14); chk("ri_epc", cp0_rdata, 32'h40);
        rd(5'd13); chk("ri_cause", cp0_rdata, 32'h0000_0028);
        rd(5'd12); chk("ri_status", cp0_rdata, 32'h0000_0403);
        tick();
        eret_dec = 1'b1;
        #1;
        chk("eret2", 32'(eret), 32'd1);
        chk("eret2_epc", epc_to_pc, 32'h40);
        tick();
        eret_dec = 1'b0;
        #1;
        chk("eret2_flush", 32'(flush), 32'd1);

        // syscall held under decode stall for three cycles
        tick();
        syscall_dec = 1'b1; s_rst_dec = 1'b1; pc_dec = 32'h80;
        #1;
        chk("stall1", 32'(exeption), 32'd0);
        tick(); chk("stall2", 32'(exeption), 32'd0);
        tick(); chk("stall3", 32'(exeption), 32'd0);
        tick();
        s_rst_dec = 1'b0;
        #1;
        chk("stall_release", 32'(exeption), 32'd1);
        tick();
        syscall_dec = 1'b0;
        #1;
        chk("sys_flush", 32'(flush), 32'd1);
        rd(5'd13); chk("sys_cause", cp0_rdata, 32'h0000_0020);
        rd(5'd14); chk("sys_epc", cp0_rdata, 32'h80);
        tick();
        eret_dec = 1'b1;
        #1;
        chk("eret3", 32'(eret), 32'd1);
        tick();
        eret_dec = 1'b0;

        // Timer: Count=0, Compare=5, Status IM7+IE
        tick();
        mtc0_dec = 1'b1; cp0_addr = 5'd9; cp0_wdata = 32'd0;
        tick();
        mtc0_dec = 1'b0;
        #1;
        chk("count_load", cp0_rdata, 32'd0);
        mtc0_dec = 1'b1; cp0_addr = 5'd11; cp0_wdata = 32'd5;
        #1;
        chk("mfc0_old_compare", cp0_rdata, 32'hFFFF_FFFF);
        tick();
        cp0_addr = 5'd12; cp0_wdata = 32'h0000_8001;
        tick();
        mtc0_dec = 1'b0;
        #1;
        chk("timer_wait0", 32'(exeption), 32'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("timer_wait%0d", k), 32'(exeption), 32'd0);
        end
        rd(5'd9); chk("count_eq_compare", cp0_rdata, 32'd5);
        tick();
        pc_dec = 32'h200;
        #1;
        chk("timer_exc", 32'(exeption), 32'd1);
        tick();
        chk("timer_flush", 32'(flush), 32'd1);
        rd(5'd13); chk("timer_cause", cp0_rdata, 32'h0000_8000);
        rd(5'd14); chk("timer_epc", cp0_rdata, 32'h200);
        tick();
        mtc0_dec = 1'b1; cp0_addr = 5'd11; cp0_wdata = 32'h100;
        #1;
        chk("timer_exl_mask", 32'(exeption), 32'd0);
        tick();
        mtc0_dec = 1'b0;
        rd(5'd13); chk("timer_clear", cp0_rdata, 32'd0);
        rd(5'd9);  chk("count_run", cp0_rdata, 32'd9);

        // Reset asserted during the flush cycle after an eret
        eret_dec = 1'b1;
        #1;
        chk("eret4", 32'(eret), 32'd1);
        tick();
        eret_dec = 1'b0;
        #1;
        chk("eret4_flush", 32'(flush), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_flush", 32'(flush), 32'd0);
        rd(5'd11); chk("midrst_compare", cp0_rdata, 32'hFFFF_FFFF);
        rd(5'd12); chk("midrst_status",  cp0_rdata, 32'd0);
        rd(5'd9);  chk("midrst_count",   cp0_rdata, 32'd0);
        rd(5'd14); chk("midrst_epc",     cp0_rdata, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_flush", 32'(flush), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
